ifu_fq: RTL
===========

# ifu_fq

Parametrised instruction fetch unit with a decoupled fetch queue, sitting between the instruction memory port and the decode stage of the pipelined core. It issues one fetch request at a time on a valid/ready request channel and accepts responses with arbitrary latency. It buffers fetched instructions with their PCs in a FIFO of configurable depth and presents them to decode on a valid/ready handshake. A redirect flushes the queue and squashes any in-flight fetch.

## Interface
- XLEN, 64: PC/address width.
- RESET_PC, 64'h8000_0000: first fetch address after reset.
- FQ_DEPTH, 4: fetch queue entries; power of two, ≥2.
- NOP_INSTR, 32'h0000_0013: value driven on id_instr when the queue is empty.

- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address (= fetch PC register).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid (one cycle per accepted request).
- imem_rsp_instr  in  32  fetched instruction.
- redirect_en  in  1  control-flow redirect (jump/branch/exception).
- redirect_pc  in  XLEN  redirect target.
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode accepts head; low = hazard stall.
- id_pc  out  XLEN  head PC; 0 when empty.
- id_instr  out  32  head instruction; NOP_INSTR when empty.
- id_snxt_pc  out  XLEN  id_pc+4 when valid; 0 when empty.

## Operation
- FSM states: REQ (no outstanding fetch), WAIT (one outstanding, result wanted), DROP (one outstanding, result to be discarded).
- imem_req_valid = (state==REQ) & (count < FQ_DEPTH) & !redirect_en.
- REQ: on req handshake, record req_pc=pc, pc<=pc+4 (mod 2^XLEN), go to WAIT. imem_rsp_valid in REQ is ignored.
- WAIT: on imem_rsp_valid, push {req_pc, imem_rsp_instr} and go to REQ. No overflow is possible because the request required free space.
- DROP: on imem_rsp_valid, discard the response and go to REQ. No requests issue in DROP.
- Pop on id_valid & id_ready. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority): pc<=redirect_pc; queue cleared (count=0, pointers reset).
  - In WAIT without same-cycle rsp: go to DROP.
  - In WAIT with same-cycle rsp: drop the response, go to REQ.
  - In DROP: stay in DROP unless rsp arrives same cycle, then go to REQ.
  - In REQ: stay in REQ; no request issued that cycle.
- Same-cycle pop and redirect: the queue is cleared; the pop is irrelevant.
- Pointers wrap modulo FQ_DEPTH; count ranges 0..FQ_DEPTH.

## Timing
- Reset values: pc=RESET_PC, state=REQ, count=0, id_valid=0, id_pc=0, id_instr=NOP_INSTR, id_snxt_pc=0, imem_req_valid=1 (first cycle after reset), imem_req_addr=RESET_PC.
- Reset mid-operation discards the outstanding fetch state. The memory side must also be reset.
- Request accepted at cycle T: the response arrives at T+k (k≥1), and the entry is visible on id_* at T+k+1.
- Peak throughput: one instruction per 2 cycles with k=1.
- id_* are driven from queue registers only, with no combinational path from imem_rsp_* or id_ready.
- imem_req_valid depends combinationally on redirect_en.
- Redirect at T: id_valid=0 at T+1. The first request to redirect_pc issues at T+1 if the state is REQ at T+1, otherwise at the cycle after the dropped response.

## Configuration
- IFU_FQ_PERF_EN defined: adds output ports perf_fetch_cnt, perf_stall_cnt and perf_redirect_cnt, each 64 bits. They reset to 0 and wrap on overflow.
  - perf_fetch_cnt counts pushes.
  - perf_stall_cnt counts cycles with id_valid & !id_ready.
  - perf_redirect_cnt counts cycles with redirect_en.
- IFU_FQ_PERF_EN undefined: the counters and ports are absent. Functional behaviour is identical.

## Test plan
- Reset, imem_req_ready=1, rsp latency 1, id_ready=1, instr=addr[31:0]: id_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008… with id_snxt_pc=id_pc+4.
- id_ready=0 for 20 cycles, FQ_DEPTH=4: exactly 4 pushes, then imem_req_valid=0. Releasing id_ready drains the 4 in order, then fetching resumes at 0x8000_0010.
- Redirect to 0x8000_1000 while in WAIT, with the rsp arriving 3 cycles later: the response is discarded, id_valid=0, and the next request addr is 0x8000_1000.
- Redirect in the same cycle as a rsp and a pop: the queue is empty next cycle, state is REQ, and the request to redirect_pc issues.
- imem_req_ready held low for 5 cycles: imem_req_valid and imem_req_addr stay stable; id_instr=0x13, id_valid=0 throughout.
- With IFU_FQ_PERF_EN: after scenario 2, perf_stall_cnt = number of cycles with id_valid&!id_ready, and perf_fetch_cnt = number of pushes.

Source files
------------

// File: rtl/ifu_fq.sv
// ifu_fq: instruction fetch unit with a decoupled fetch queue.
// Issues one fetch at a time to instruction memory, buffers returned
// instructions with their PCs in a FIFO, and hands them to decode.
// A redirect flushes the queue and squashes any in-flight fetch.
// Optional build macro: IFU_FQ_PERF_EN adds 64-bit performance counters.
module ifu_fq #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = 64'h8000_0000,
    parameter int              FQ_DEPTH  = 4,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_instr,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_snxt_pc
`ifdef IFU_FQ_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt,
    output logic [63:0]     perf_redirect_cnt
`endif
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FQ_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] req_pc_r;
    logic [XLEN-1:0] q_pc_r    [FQ_DEPTH];
    logic [31:0]     q_instr_r [FQ_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            req_fire_s;
    logic            push_s;
    logic            pop_s;

    assign imem_req_valid = (state_r == S_REQ) && (count_r < DEPTH_C) && !redirect_en;
    assign imem_req_addr  = pc_r;
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign push_s         = (state_r == S_WAIT) && imem_rsp_valid && !redirect_en;
    assign id_valid       = (count_r != {CW{1'b0}});
    assign pop_s          = id_valid && id_ready;

    // Next fetch state: a redirect turns an outstanding wanted fetch into a dropped one.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_REQ: begin
                if (req_fire_s) state_s = S_WAIT;
                else            state_s = S_REQ;
            end
            S_WAIT: begin
                if (imem_rsp_valid)   state_s = S_REQ;
                else if (redirect_en) state_s = S_DROP;
                else                  state_s = S_WAIT;
            end
            S_DROP: begin
                if (imem_rsp_valid) state_s = S_REQ;
                else                state_s = S_DROP;
            end
            default: state_s = S_REQ;
        endcase
    end

    // Fetch state, fetch PC and PC of the outstanding request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r  <= S_REQ;
            pc_r     <= RESET_PC;
            req_pc_r <= RESET_PC;
        end else begin
            state_r <= state_s;
            if (redirect_en) begin
                pc_r <= redirect_pc;
            end else if (req_fire_s) begin
                pc_r     <= pc_r + PC_STEP;
                req_pc_r <= pc_r;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (redirect_en) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only observed while the entry is valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_pc_r[wr_ptr_r]    <= req_pc_r;
            q_instr_r[wr_ptr_r] <= imem_rsp_instr;
        end
    end

    // Decode-side view of the queue head, neutral values when empty.
    always_comb begin
        id_pc      = {XLEN{1'b0}};
        id_instr   = NOP_INSTR;
        id_snxt_pc = {XLEN{1'b0}};
        if (id_valid) begin
            id_pc      = q_pc_r[rd_ptr_r];
            id_instr   = q_instr_r[rd_ptr_r];
            id_snxt_pc = q_pc_r[rd_ptr_r] + PC_STEP;
        end else begin
            id_pc      = {XLEN{1'b0}};
            id_instr   = NOP_INSTR;
            id_snxt_pc = {XLEN{1'b0}};
        end
    end

`ifdef IFU_FQ_PERF_EN
    // Performance counters: pushes, decode stall cycles and redirect cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fetch_cnt    <= 64'd0;
            perf_stall_cnt    <= 64'd0;
            perf_redirect_cnt <= 64'd0;
        end else begin
            if (push_s)                perf_fetch_cnt    <= perf_fetch_cnt + 64'd1;
            if (id_valid && !id_ready) perf_stall_cnt    <= perf_stall_cnt + 64'd1;
            if (redirect_en)           perf_redirect_cnt <= perf_redirect_cnt + 64'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
